// File: rtl/conv_enc_k3.sv
// Rate-1/2, K=3 convolutional encoder (g0=111, g1=101) with valid/ready framing.
// Each frame of FRAME_LEN data bits is followed by two zero tail bits, so the trellis ends in state 00.
module conv_enc_k3 #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       sym_last,
  output logic       frame_done,
  output logic       busy,
  output logic [1:0] enc_state
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t          r_fsm;
  logic [1:0]      r_enc;
  logic [CW-1:0]   r_cnt;
  logic            r_tail;
  logic [1:0]      r_sym;
  logic            r_vld;
  logic            r_last;
  logic            r_done;
  logic            w_slot_free;

  // Symbol {c0,c1} for input u in state {s1,s0}, s1 being the newest bit.
  function automatic logic [1:0] enc_sym(input logic u, input logic [1:0] st);
    return {u ^ st[1] ^ st[0], u ^ st[0]};
  endfunction

  assign w_slot_free = !r_vld | sym_ready;
  assign din_ready   = (r_fsm == DATA) & w_slot_free;
  assign sym_out     = r_sym;
  assign sym_valid   = r_vld;
  assign sym_last    = r_last;
  assign frame_done  = r_done;
  assign busy        = (r_fsm != IDLE) | r_vld;
  assign enc_state   = r_enc;

  // Framing FSM, encoder shift register and registered output slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm  <= IDLE;
      r_enc  <= 2'b00;
      r_cnt  <= '0;
      r_tail <= 1'b0;
      r_sym  <= 2'b00;
      r_vld  <= 1'b0;
      r_last <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_vld & sym_ready & r_last;
      // A consumed symbol frees the slot unless a new one is loaded below.
      if (r_vld & sym_ready) begin
        r_vld  <= 1'b0;
        r_last <= 1'b0;
      end
      case (r_fsm)
        IDLE: begin
          if (start) begin
            r_fsm <= DATA;
            r_enc <= 2'b00;
            r_cnt <= '0;
          end
        end
        DATA: begin
          if (din_valid & w_slot_free) begin
            r_sym  <= enc_sym(din, r_enc);
            r_vld  <= 1'b1;
            r_last <= 1'b0;
            r_enc  <= {din, r_enc[1]};
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == LAST_CNT) begin
              r_fsm  <= TAIL;
              r_tail <= 1'b0;
            end
          end
        end
        TAIL: begin
          if (w_slot_free) begin
            r_sym  <= enc_sym(1'b0, r_enc);
            r_vld  <= 1'b1;
            r_last <= r_tail;
            r_enc  <= {1'b0, r_enc[1]};
            if (r_tail) begin
              r_fsm <= IDLE;
            end else begin
              r_tail <= 1'b1;
            end
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_k3.sv
// Scoreboard bench for conv_enc_k3: a tap-based reference pushes expected symbols,
// a negedge monitor pops them on every symbol handshake.
module tb_conv_enc_k3;
  localparam int FRAME_LEN = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       sym_ready;
  logic       sym_last;
  logic       frame_done;
  logic       busy;
  logic [1:0] enc_state;

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] sb[$];
  logic [1:0] got[$];
  logic       m_u1;
  logic       m_u2;
  logic       last_hs;
  int         sym_cnt;

  typedef logic [1:0] sym_tab_t [10];
  sym_tab_t   t2_tab = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
  sym_tab_t   t3_tab = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
  logic [FRAME_LEN-1:0] t2_bits = 8'b0000_1101;
  logic [FRAME_LEN-1:0] t3_bits = 8'b1111_1111;

  always #5 clk = ~clk;

  conv_enc_k3 #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_last   (sym_last),
    .frame_done (frame_done),
    .busy       (busy),
    .enc_state  (enc_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: c0 = u ^ u[-1] ^ u[-2], c1 = u ^ u[-2].
  task automatic push_exp(input logic u, input logic last);
    logic c0;
    logic c1;
    c0 = u ^ m_u1 ^ m_u2;
    c1 = u ^ m_u2;
    sb.push_back({c0, c1, last});
    m_u2 = m_u1;
    m_u1 = u;
  endtask

  task automatic start_frame();
    m_u1  = 1'b0;
    m_u2  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input logic last_bit);
    int t;
    din       = b;
    din_valid = 1'b1;
    t         = 0;
    @(negedge clk);
    while (!din_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!din_ready) begin
      chk("din_ready_timeout", 32'd0, 32'd1);
    end else begin
      push_exp(b, 1'b0);
      if (last_bit) begin
        push_exp(1'b0, 1'b0);
        push_exp(1'b0, 1'b1);
      end
    end
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [FRAME_LEN-1:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive_bit(bits[i], (i == FRAME_LEN - 1) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_got(input string tag, input sym_tab_t tab);
    chk({tag, "_len"}, 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      chk({tag, "_sym"}, 32'(got[i]), 32'(tab[i]));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sym_valid"},  32'(sym_valid),  32'd0);
    chk({tag, "_sym_out"},    32'(sym_out),    32'd0);
    chk({tag, "_sym_last"},   32'(sym_last),   32'd0);
    chk({tag, "_din_ready"},  32'(din_ready),  32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_enc_state"},  32'(enc_state),  32'd0);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    #1 chk_reset_vals(tag);
    sb.delete();
    got.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk({tag, "_din_ready_after"}, 32'(din_ready), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on each handshake and tracks frame_done and symbol count.
  initial begin
    last_hs = 1'b0;
    sym_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        last_hs = 1'b0;
        sym_cnt = 0;
      end else begin
        chk("frame_done", 32'(frame_done), 32'(last_hs));
        last_hs = 1'b0;
        if (sym_valid && sym_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_sym", 32'd1, 32'd0);
          end else begin
            chk("sym_out",  32'(sym_out),  32'(sb[0][2:1]));
            chk("sym_last", 32'(sym_last), 32'(sb[0][0]));
            void'(sb.pop_front());
          end
          got.push_back(sym_out);
          sym_cnt++;
          if (sym_last) begin
            chk("sym_count", 32'(sym_cnt), 32'(FRAME_LEN + 2));
            sym_cnt = 0;
            last_hs = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    sym_ready = 1'b1;
    #1 chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // T1: reset in the middle of a frame
    start_frame();
    send_bits(t2_bits, 0, 1);
    apply_reset("t1");

    // T2: reference frame at full throughput
    got.delete();
    start_frame();
    send_bits(t2_bits, 0, FRAME_LEN - 1);
    wait_idle();
    check_got("t2", t2_tab);
    chk("t2_enc_state", 32'(enc_state), 32'd0);

    // T3: all-ones frame
    got.delete();
    start_frame();
    send_bits(t3_bits, 0, FRAME_LEN - 1);
    wait_idle();
    check_got("t3", t3_tab);
    chk("t3_enc_state", 32'(enc_state), 32'd0);

    // T4: three cycles of backpressure after the 3rd symbol
    got.delete();
    start_frame();
    send_bits(t2_bits, 0, 2);
    sym_ready = 1'b0;
    din       = t2_bits[3];
    din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_sym",   32'(sym_out),   32'd0);
      chk("t4_hold_valid", 32'(sym_valid), 32'd1);
      chk("t4_hold_ready", 32'(din_ready), 32'd0);
    end
    @(posedge clk);
    #1 sym_ready = 1'b1;
    send_bits(t2_bits, 3, FRAME_LEN - 1);
    wait_idle();
    check_got("t4", t2_tab);

    // T5: abort after 4 bits, then a clean T3 frame
    start_frame();
    send_bits(t2_bits, 0, 3);
    apply_reset("t5");
    got.delete();
    start_frame();
    send_bits(t3_bits, 0, FRAME_LEN - 1);
    wait_idle();
    check_got("t5", t3_tab);

    // T6: din_valid in IDLE, start pulses in DATA and TAIL
    din       = 1'b1;
    din_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_idle_ready", 32'(din_ready), 32'd0);
      chk("t6_idle_valid", 32'(sym_valid), 32'd0);
    end
    @(posedge clk);
    #1 din_valid = 1'b0;
    got.delete();
    start_frame();
    send_bits(t2_bits, 0, 3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    send_bits(t2_bits, 4, FRAME_LEN - 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    check_got("t6", t2_tab);
    repeat (3) begin
      @(negedge clk);
      chk("t6_stays_idle", 32'(busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
